// File: rtl/weighted_rr_pkg.sv
// Shared types and helpers for the weighted round-robin scheduler.
package weighted_rr_pkg;

  // Requester count the scheduler is built and verified for.
  localparam int unsigned DefaultNumReq = 4;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StHandoff = 2'd2
  } sched_state_e;

  // Index increment with wrap from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, otherwise the lowest asserted request (wrap-around search).
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    pointer,
  output logic               found,
  output logic [IdxW-1:0]    winner
);

  logic [NUM_REQ-1:0] ge_mask;
  logic [NUM_REQ-1:0] masked;

  // Requests at or above the pointer take priority over the wrapped ones.
  assign ge_mask = {NUM_REQ{1'b1}} << pointer;
  assign masked  = req & ge_mask;
  assign found   = |req;

  // Lowest set bit of the masked vector, falling back to the raw vector.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IdxW'(i);
    end
    if (|masked) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (masked[i]) winner = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_scheduler.sv
// Time-sliced, work-conserving weighted round-robin scheduler. An owner keeps
// the grant for weight+1 slices unless it drops its request or releases early;
// owners are separated by a one-cycle dead handoff.
module weighted_rr_scheduler
  import weighted_rr_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DefaultNumReq,
  parameter int unsigned SLICE_CYCLES = 150000000,
  parameter int unsigned WEIGHT_W     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           request_queue,
  input  logic [NUM_REQ-1:0]           release_in,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg,
  output logic [NUM_REQ-1:0]           grant_out,
  output logic                         grant_valid,
  output logic                         slice_tick
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(SLICE_CYCLES);
  localparam logic [CntW-1:0] SliceLast = CntW'(SLICE_CYCLES - 1);

  sched_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]          owner_q, owner_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]      quanta_q, quanta_d;

  logic                     pick_found;
  logic [IdxW-1:0]          pick_idx;
  logic [WEIGHT_W-1:0]      weights [NUM_REQ];
  logic                     slice_end;
  logic                     owner_exit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (request_queue),
    .pointer (ptr_q),
    .found   (pick_found),
    .winner  (pick_idx)
  );

  // Unpack the flat weight bus into one field per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      weights[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign slice_end  = (state_q == StGrant) && (cnt_q == SliceLast);
  // Any of: last slice done, owner withdrew its request, owner released early.
  assign owner_exit = (slice_end && (quanta_q == '0)) ||
                      !request_queue[owner_q] ||
                      release_in[owner_q];

  assign grant_out   = grant_q;
  assign grant_valid = |grant_q;
  assign slice_tick  = slice_end;

  // Next-state logic for the FSM, grant register, pointer and counters.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    quanta_d = quanta_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d  = StGrant;
          grant_d  = NUM_REQ'(1) << pick_idx;
          owner_d  = pick_idx;
          cnt_d    = '0;
          // Weight is captured here so later config changes leave this grant alone.
          quanta_d = weights[pick_idx];
        end
      end
      StGrant: begin
        cnt_d = slice_end ? '0 : cnt_q + 1'b1;
        if (slice_end && (quanta_q != '0)) quanta_d = quanta_q - 1'b1;
        if (owner_exit) begin
          state_d = StHandoff;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = IdxW'(wrap_inc(32'(owner_q), NUM_REQ));
        end
      end
      StHandoff: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      quanta_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      quanta_q <= quanta_d;
    end
  end

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Directed bench for weighted_rr_scheduler with 4-cycle slices.
module tb_weighted_rr_scheduler;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned Slice   = 4;
  localparam int unsigned WeightW = 2;

  logic                        clk;
  logic                        reset;
  logic [NumReq-1:0]           request_queue;
  logic [NumReq-1:0]           release_in;
  logic [NumReq*WeightW-1:0]   weight_cfg;
  logic [NumReq-1:0]           grant_out;
  logic                        grant_valid;
  logic                        slice_tick;

  int n_vec;
  int n_miscmp;

  weighted_rr_scheduler #(
    .NUM_REQ      (NumReq),
    .SLICE_CYCLES (Slice),
    .WEIGHT_W     (WeightW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .request_queue (request_queue),
    .release_in    (release_in),
    .weight_cfg    (weight_cfg),
    .grant_out     (grant_out),
    .grant_valid   (grant_valid),
    .slice_tick    (slice_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles; returns 1 unit after an edge with reset released.
  task automatic do_reset();
    reset         = 1'b1;
    request_queue = '0;
    release_in    = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    n_vec         = 0;
    n_miscmp      = 0;
    reset         = 1'b1;
    request_queue = '0;
    release_in    = '0;
    weight_cfg    = '0;

    // Idle with no requests: everything stays low.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq($sformatf("idle grant c%0d", c), 32'(grant_out), 32'h0);
      check_eq($sformatf("idle valid c%0d", c), 32'(grant_valid), 32'h0);
      check_eq($sformatf("idle tick c%0d", c), 32'(slice_tick), 32'h0);
    end

    // All requesting: 0,1,2,3,0 each for 4 cycles with 2-cycle gaps.
    do_reset();
    request_queue = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 6; c++) begin
        step();
        exp_g = (c < 4) ? (4'b0001 << (k % 4)) : 4'b0000;
        check_eq($sformatf("rr grant k%0d c%0d", k, c), 32'(grant_out), 32'(exp_g));
        check_eq($sformatf("rr valid k%0d c%0d", k, c), 32'(grant_valid), 32'(c < 4));
        check_eq($sformatf("rr tick k%0d c%0d", k, c), 32'(slice_tick), 32'(c == 3));
      end
    end

    // Weight 3 on requester 2: 16-cycle grant; weight change mid-grant is
    // only seen by the next grant (4 cycles).
    do_reset();
    weight_cfg    = 8'h30;
    request_queue = 4'b0100;
    for (int c = 0; c < 24; c++) begin
      step();
      if (c == 0) weight_cfg = 8'h00;
      exp_g = ((c < 16) || (c >= 18 && c < 22)) ? 4'b0100 : 4'b0000;
      check_eq($sformatf("w3 grant c%0d", c), 32'(grant_out), 32'(exp_g));
      check_eq($sformatf("w3 tick c%0d", c), 32'(slice_tick),
               32'(((c < 16) && (c % 4 == 3)) || (c == 21)));
    end

    // Early release by owner 0; pointer moves to 1 and finds 3, then wraps to 0.
    do_reset();
    request_queue = 4'b1001;
    for (int c = 0; c < 11; c++) begin
      step();
      release_in = (c == 1) ? 4'b0001 : 4'b0000;
      exp_g = (c < 2) ? 4'b0001 :
              (c >= 4 && c < 8) ? 4'b1000 :
              (c == 10) ? 4'b0001 : 4'b0000;
      check_eq($sformatf("rel grant c%0d", c), 32'(grant_out), 32'(exp_g));
    end

    // Owner 1: non-owner release ignored, then drop+release together gives
    // a single handoff and a re-grant two cycles later.
    do_reset();
    request_queue = 4'b0010;
    step();
    check_eq("drop c0", 32'(grant_out), 32'h2);
    release_in = 4'b0100;
    step();
    check_eq("drop c1", 32'(grant_out), 32'h2);
    release_in = 4'b0000;
    step();
    check_eq("nonowner rel c2", 32'(grant_out), 32'h2);
    request_queue = 4'b0000;
    release_in    = 4'b0010;
    step();
    check_eq("drop handoff grant", 32'(grant_out), 32'h0);
    check_eq("drop handoff valid", 32'(grant_valid), 32'h0);
    request_queue = 4'b0010;
    release_in    = 4'b0000;
    step();
    check_eq("drop idle grant", 32'(grant_out), 32'h0);
    step();
    check_eq("drop regrant", 32'(grant_out), 32'h2);
    check_eq("drop regrant valid", 32'(grant_valid), 32'h1);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    request_queue = 4'b0100;
    step();
    step();
    check_eq("pre async grant", 32'(grant_out), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async grant", 32'(grant_out), 32'h0);
    check_eq("async valid", 32'(grant_valid), 32'h0);
    request_queue = 4'b1111;
    step();
    step();
    reset = 1'b0;
    step();
    check_eq("post reset grant", 32'(grant_out), 32'h1);
    check_eq("post reset valid", 32'(grant_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/weighted_rr_scheduler.md
Name: weighted_rr_scheduler

Overview:
- Time-sliced, work-conserving, weighted round-robin scheduler. It shares one resource (LED bank / shared bus) among 4 request queues.
- Unlike a fixed rotating token, it grants only requesters that are asserting.
- Each grant holds for a configurable number of time slices, or until the requester releases or drops its request.
- A one-cycle dead handoff separates owners.
- Sits between the request-queue sources and the shared resource's select lines.

Parameters:
- NUM_REQ, 4, number of requesters; the design is verified at 4 only.
- SLICE_CYCLES, 150000000, clock cycles per time slice (3 s at 50 MHz); must be >= 2.
- WEIGHT_W, 2, width of each per-requester weight field.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- request_queue  input  NUM_REQ  level request, bit i = requester i
- release_in  input  NUM_REQ  one-cycle pulse; requester i finished early (ignored unless i is the current owner)
- weight_cfg  input  NUM_REQ*WEIGHT_W  weight of requester i at bits [i*WEIGHT_W +: WEIGHT_W]; grant lasts weight+1 slices
- grant_out  output  NUM_REQ  one-hot grant, registered; all-zero when no owner
- grant_valid  output  1  high while grant_out is non-zero
- slice_tick  output  1  one-cycle pulse at the last cycle of each slice while in GRANT

Behaviour:
- Reset (async, high): state=IDLE, grant_out=0, grant_valid=0, slice_tick=0, pointer=0, slice counter=0, quanta counter=0.
- States: IDLE, GRANT, HANDOFF. Encoding is defined in the package.
- IDLE:
  - Each cycle, the picker selects the first asserted request_queue bit, searching from pointer upward with wrap 3->0.
  - If one is found, on the next edge: state=GRANT, grant_out=onehot(winner), grant_valid=1, owner latched, slice counter=0.
  - quanta_left is loaded with weight_cfg[owner]; the weight is latched at grant time, and later weight_cfg changes do not affect the current grant.
  - Latency from request at an edge to grant_out high: 1 cycle.
  - If no request is found, stay in IDLE with outputs 0.
- GRANT:
  - The slice counter increments every cycle.
  - When it reaches SLICE_CYCLES-1: slice_tick=1 that cycle, the counter wraps to 0, and quanta_left decrements if non-zero.
  - Exit to HANDOFF on the next edge if any of these holds:
    - (a) slice end with quanta_left==0
    - (b) request_queue[owner]==0
    - (c) release_in[owner]==1
  - Simultaneous exit causes produce exactly one handoff.
- HANDOFF: lasts exactly 1 cycle with grant_out=0 and grant_valid=0. pointer=(owner+1) mod NUM_REQ. Next state is IDLE.
  - IDLE arbitrates in its first cycle, so the gap between successive owners is 2 cycles.
- Weight arithmetic: total grant = (weight+1)*SLICE_CYCLES cycles. Weight 0 = 1 slice; weight 3 = 4 slices.
- Single active requester: it is re-granted after each HANDOFF/IDLE gap. No starvation, no lockout.
- All requests dropped during GRANT: HANDOFF then IDLE, with outputs 0.
- release_in for a non-owner bit: ignored, no state change.
- grant_out is never more than one-hot. It is never asserted for a requester whose request_queue bit was 0 at the arbitration edge.
- Reset asserted mid-GRANT: outputs clear immediately (async) and pointer returns to 0.

Decomposition:
- Package weighted_rr_pkg:
  - state enum: IDLE, GRANT, HANDOFF
  - NUM_REQ default constant
  - helper function for wrap-increment of the pointer
- Sub-module rr_priority_picker (combinational):
  - inputs: req vector, pointer
  - outputs: found flag, winner index
  - implementation: rotate-mask priority encoder

Test Plan (SLICE_CYCLES=4, all weights=0 unless stated):
- Reset, request_queue=0000 -> grant_out=0000 and grant_valid=0 indefinitely; slice_tick never pulses.
- request_queue=1111 held -> grants cycle 0001, 0010, 0100, 1000, 0001; each lasts 4 cycles; each is followed by a 2-cycle gap of 0000.
- weight_cfg requester 2 = 3, request_queue=0100 -> grant_out=0100 for 16 cycles; slice_tick pulses 4 times; then the gap; then 0100 is re-granted.
- request_queue=1001 with owner 0 -> release_in=0001 at cycle 1 -> HANDOFF next edge; the next grant is 1000 (pointer wraps to 1, finds 3); the following grant is 0001.
- Owner 1 active; drop request_queue[1] and pulse release_in[1] on the same cycle -> exactly one HANDOFF cycle; release_in=0100 to a non-owner is ignored.
- Assert reset mid-slice during a 0100 grant -> grant_out=0000 without waiting for a clock edge; after release with request_queue=1111 -> first grant is 0001.
